// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and its request checker:
// MemOp encodings, arbiter FSM states and the per-op access size.
package dmem_pkg;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_BS = 3'b001;
  localparam logic [2:0] OP_HS = 3'b010;
  localparam logic [2:0] OP_BU = 3'b101;
  localparam logic [2:0] OP_HU = 3'b110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Bytes touched by an access; illegal ops report 1 and are rejected elsewhere.
  function automatic logic [2:0] op_size(input logic [2:0] op);
    case (op)
      OP_W:         op_size = 3'd4;
      OP_HS, OP_HU: op_size = 3'd2;
      default:      op_size = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational legality check for one memory request: illegal op,
// misalignment, or a byte range that runs past the end of memory.
module dmem_req_check
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 32
) (
  input  logic              we,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  output logic              err
);

  logic        op_ok;
  logic        misaligned;
  logic [63:0] last_byte;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    op_ok      = 1'b0;
    misaligned = 1'b0;
    case (op)
      OP_W, OP_BS, OP_HS: op_ok = 1'b1;
      OP_BU, OP_HU:       op_ok = !we;
      default:            op_ok = 1'b0;
    endcase
    if (op == OP_W)
      misaligned = (addr[1:0] != 2'b00);
    else if (op == OP_HS || op == OP_HU)
      misaligned = addr[0];
    // Widened so an address near the top of the 32-bit space cannot wrap.
    last_byte = 64'(addr) + 64'(op_size(op)) - 64'd1;
    err       = !op_ok || misaligned || (last_byte >= 64'(DEPTH));
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between port 0 (LSU) and
// port 1 (DMA/debug); one access in flight, IDLE -> ACCESS -> RESP.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [2:0]        op0,
  input  logic [2:0]        op1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              mem_WrEn,
  output logic              mem_MemEn,
  output logic [2:0]        mem_MemOp,
  output logic [ADDR_W-1:0] mem_Addr,
  output logic [31:0]       mem_DataIn,
  input  logic [31:0]       mem_DataOut
);

  state_t            state_q, state_d;
  logic              rr_q;
  logic              id_q, we_q, err_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;

  logic              sel, sel_we, sel_err;
  logic [2:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  // rr_q names the port that wins a tie.
  assign sel       = (req0 && req1) ? rr_q : req1;
  assign sel_we    = sel ? we1    : we0;
  assign sel_op    = sel ? op1    : op0;
  assign sel_addr  = sel ? addr1  : addr0;
  assign sel_wdata = sel ? wdata1 : wdata0;

  dmem_req_check #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_check (
    .we   (sel_we),
    .op   (sel_op),
    .addr (sel_addr),
    .err  (sel_err)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: latched request fields are pure datapath and are only read after a latch, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && (req0 || req1)) begin
      id_q    <= sel;
      we_q    <= sel_we;
      op_q    <= sel_op;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      err_q   <= sel_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state_q == ACCESS)
        rdata_q <= (we_q || err_q) ? 32'd0 : mem_DataOut;
      if (state_q == RESP)
        rr_q <= ~id_q;
    end
  end

  assign rdata = rdata_q;

  // Every output is held low while rst is high, so an aborted access never writes.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rvalid0    = 1'b0;
    rvalid1    = 1'b0;
    err        = 1'b0;
    mem_WrEn   = 1'b0;
    mem_MemEn  = 1'b0;
    mem_MemOp  = 3'b000;
    mem_Addr   = '0;
    mem_DataIn = '0;
    if (!rst) begin
      case (state_q)
        ACCESS: begin
          gnt0       = !id_q;
          gnt1       = id_q;
          mem_MemEn  = !err_q;
          mem_WrEn   = we_q && !err_q;
          mem_MemOp  = op_q;
          mem_Addr   = addr_q;
          mem_DataIn = wdata_q;
        end
        RESP: begin
          rvalid0 = !id_q;
          rvalid1 = id_q;
          err     = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array memory model attached
// to the mem_* interface.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [2:0]  op0, op1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err;
  logic [31:0] rdata;
  logic        mem_WrEn, mem_MemEn;
  logic [2:0]  mem_MemOp;
  logic [31:0] mem_Addr, mem_DataIn, mem_DataOut;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:4095] = '{default: 8'h00};

  dmem_arbiter #(.DEPTH(4096), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .op0(op0), .op1(op1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err),
    .mem_WrEn(mem_WrEn), .mem_MemEn(mem_MemEn), .mem_MemOp(mem_MemOp),
    .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_DataOut(mem_DataOut)
  );

  always #5 clk = ~clk;

  // Little-endian data memory: combinational read, write on posedge.
  logic [11:0] ix;
  always_comb begin
    ix          = mem_Addr[11:0];
    mem_DataOut = 32'd0;
    if (mem_MemEn) begin
      case (mem_MemOp)
        3'b000:  mem_DataOut = {mem[ix + 12'd3], mem[ix + 12'd2], mem[ix + 12'd1], mem[ix]};
        3'b001:  mem_DataOut = {{24{mem[ix][7]}}, mem[ix]};
        3'b101:  mem_DataOut = {24'd0, mem[ix]};
        3'b010:  mem_DataOut = {{16{mem[ix + 12'd1][7]}}, mem[ix + 12'd1], mem[ix]};
        3'b110:  mem_DataOut = {16'd0, mem[ix + 12'd1], mem[ix]};
        default: mem_DataOut = 32'd0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_MemEn && mem_WrEn) begin
      case (mem_MemOp)
        3'b000: begin
          mem[ix]          <= mem_DataIn[7:0];
          mem[ix + 12'd1]  <= mem_DataIn[15:8];
          mem[ix + 12'd2]  <= mem_DataIn[23:16];
          mem[ix + 12'd3]  <= mem_DataIn[31:24];
        end
        3'b001: mem[ix] <= mem_DataIn[7:0];
        3'b010: begin
          mem[ix]         <= mem_DataIn[7:0];
          mem[ix + 12'd1] <= mem_DataIn[15:8];
        end
        default: ;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input logic r, input logic w, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p) begin req1 = r; we1 = w; op1 = op; addr1 = a; wdata1 = wd; end
    else   begin req0 = r; we0 = w; op0 = op; addr0 = a; wdata0 = wd; end
  endtask

  // Runs one access on port p and reports what was seen at grant and response.
  task automatic do_access(input bit p, input logic w, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic both, output logic wren,
                           output logic memen, output logic [31:0] maddr,
                           output logic rv, output logic rv_other,
                           output logic rerr, output logic [31:0] rd);
    drive(p, 1'b1, w, op, a, wd);
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!(p ? gnt1 : gnt0) && lat < 8);
    if (!(p ? gnt1 : gnt0)) lat = -1;
    both  = gnt0 && gnt1;
    wren  = mem_WrEn;
    memen = mem_MemEn;
    maddr = mem_Addr;
    drive(p, 1'b0, w, op, a, wd);
    cyc();
    rv       = p ? rvalid1 : rvalid0;
    rv_other = p ? rvalid0 : rvalid1;
    rerr     = err;
    rd       = rdata;
    cyc();
  endtask

  task automatic test_reset();
    logic [105:0] outs;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      outs = {gnt0, gnt1, rvalid0, rvalid1, err, rdata, mem_WrEn, mem_MemEn,
              mem_MemOp, mem_Addr, mem_DataIn};
      n_cmp++;
      if (outs !== '0) begin
        n_bad++;
        $display("FAIL reset_idle cycle %0d: outputs %h, want all 0", i, outs);
      end
    end
  endtask

  task automatic test_store_load();
    int lat;
    logic both, wren, memen, rv, rvo, rerr;
    logic [31:0] maddr, rd;

    do_access(1'b0, 1'b1, OP_W, 32'h10, 32'hDEADBEEF, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL st_gnt_latency: got %0d want 1", lat); end
    n_cmp++; if ({wren, memen} !== 2'b11) begin n_bad++; $display("FAIL st_enables: WrEn/MemEn %b want 11", {wren, memen}); end
    n_cmp++; if (maddr !== 32'h10) begin n_bad++; $display("FAIL st_addr: got %h want 00000010", maddr); end
    n_cmp++; if ({rv, rvo, rerr} !== 3'b100) begin n_bad++; $display("FAIL st_resp: rvalid/other/err %b want 100", {rv, rvo, rerr}); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL st_rdata: got %h want 00000000", rd); end

    do_access(1'b0, 1'b0, OP_W, 32'h10, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if ({wren, memen} !== 2'b01) begin n_bad++; $display("FAIL ld_enables: WrEn/MemEn %b want 01", {wren, memen}); end
    n_cmp++; if ({rv, rerr} !== 2'b10) begin n_bad++; $display("FAIL ld_resp: rvalid/err %b want 10", {rv, rerr}); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_word: got %h want deadbeef", rd); end

    do_access(1'b1, 1'b0, OP_HU, 32'h10, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if ({rv, rvo} !== 2'b10) begin n_bad++; $display("FAIL p1_rvalid: rvalid1/rvalid0 %b want 10", {rv, rvo}); end
    n_cmp++; if (rd !== 32'h0000BEEF) begin n_bad++; $display("FAIL p1_half_u: got %h want 0000beef", rd); end

    do_access(1'b1, 1'b0, OP_HS, 32'h12, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if (rd !== 32'hFFFFDEAD) begin n_bad++; $display("FAIL p1_half_s: got %h want ffffdead", rd); end
  endtask

  task automatic test_extension();
    int lat;
    logic both, wren, memen, rv, rvo, rerr;
    logic [31:0] maddr, rd;

    do_access(1'b1, 1'b1, OP_BS, 32'h21, 32'hAAAAAA80, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if ({rv, rerr, wren} !== 3'b101) begin n_bad++; $display("FAIL sb_resp: rvalid/err/WrEn %b want 101", {rv, rerr, wren}); end

    do_access(1'b0, 1'b0, OP_BS, 32'h21, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_signed: got %h want ffffff80", rd); end

    do_access(1'b0, 1'b0, OP_BU, 32'h21, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if (rd !== 32'h00000080) begin n_bad++; $display("FAIL lb_unsigned: got %h want 00000080", rd); end

    do_access(1'b0, 1'b0, OP_HS, 32'h20, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if (rd !== 32'hFFFF8000) begin n_bad++; $display("FAIL lh_signed_20: got %h want ffff8000", rd); end
  endtask

  task automatic test_round_robin();
    int  grants [$];
    int  wants  [4] = '{0, 1, 0, 1};
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, OP_W,  32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, OP_BU, 32'h21, 32'h0);
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (c == 11) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      n_cmp++;
      if ((gnt0 && gnt1) || (rvalid0 && rvalid1)) begin
        n_bad++;
        $display("FAIL rr_exclusive cycle %0d: gnt %b%b rvalid %b%b", c, gnt0, gnt1, rvalid0, rvalid1);
      end
      if (gnt0) grants.push_back(0);
      if (gnt1) grants.push_back(1);
      if (rvalid0) begin
        n_cmp++;
        if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rr_rdata0: got %h want deadbeef", rdata); end
      end
      if (rvalid1) begin
        n_cmp++;
        if (rdata !== 32'h00000080) begin n_bad++; $display("FAIL rr_rdata1: got %h want 00000080", rdata); end
      end
    end
    n_cmp++;
    if (grants.size() != 4) begin
      n_bad++;
      $display("FAIL rr_grant_count: got %0d want 4", grants.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (grants[k] != wants[k]) begin n_bad++; $display("FAIL rr_order[%0d]: got port %0d want port %0d", k, grants[k], wants[k]); end
      end
    end
    cyc();
    cyc();
    cyc();
  endtask

  task automatic test_errors();
    int lat;
    logic both, wren, memen, rv, rvo, rerr;
    logic [31:0] maddr, rd;

    do_access(1'b0, 1'b0, OP_W, 32'h02, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if ({memen, wren} !== 2'b00) begin n_bad++; $display("FAIL err_misalign_en: MemEn/WrEn %b want 00", {memen, wren}); end
    n_cmp++; if ({rv, rerr, rd} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL err_misalign_resp: rvalid %b err %b rdata %h want 1 1 0", rv, rerr, rd); end

    do_access(1'b1, 1'b1, OP_BU, 32'h30, 32'h12345678, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if ({memen, wren, rv, rerr} !== 4'b0011) begin n_bad++; $display("FAIL err_store_op: MemEn/WrEn/rvalid/err %b want 0011", {memen, wren, rv, rerr}); end
    n_cmp++; if ({mem[12'h33], mem[12'h32], mem[12'h31], mem[12'h30]} !== 32'h0) begin n_bad++; $display("FAIL err_store_mem: mem[30] %h want 00000000", {mem[12'h33], mem[12'h32], mem[12'h31], mem[12'h30]}); end

    do_access(1'b0, 1'b0, OP_W, 32'hFFE, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if ({memen, rerr, rd} !== {2'b01, 32'h0}) begin n_bad++; $display("FAIL err_range_word: MemEn %b err %b rdata %h want 0 1 0", memen, rerr, rd); end

    do_access(1'b0, 1'b0, 3'b011, 32'h40, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if ({memen, rerr} !== 2'b01) begin n_bad++; $display("FAIL err_load_op011: MemEn/err %b want 01", {memen, rerr}); end

    do_access(1'b0, 1'b0, OP_HU, 32'hFFF, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if (rerr !== 1'b1) begin n_bad++; $display("FAIL err_half_fff: err %b want 1", rerr); end

    do_access(1'b0, 1'b0, OP_W, 32'hFFC, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if ({memen, rerr} !== 2'b10) begin n_bad++; $display("FAIL ok_word_ffc: MemEn/err %b want 10", {memen, rerr}); end

    do_access(1'b1, 1'b0, OP_BU, 32'hFFF, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if ({memen, rerr} !== 2'b10) begin n_bad++; $display("FAIL ok_byte_fff: MemEn/err %b want 10", {memen, rerr}); end

    do_access(1'b0, 1'b0, OP_W, 32'h10, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);
    n_cmp++; if ({rerr, rd} !== {1'b0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL err_mem_intact: err %b rdata %h want 0 deadbeef", rerr, rd); end
  endtask

  task automatic test_reset_mid_access();
    int lat;
    int n;
    logic both, wren, memen, rv, rvo, rerr;
    logic [31:0] maddr, rd;

    // Port 0 wins once so the tie preference points at port 1 before the abort.
    do_access(1'b0, 1'b0, OP_W, 32'h10, 32'h0, lat, both, wren, memen, maddr, rv, rvo, rerr, rd);

    drive(1'b0, 1'b1, 1'b1, OP_W, 32'h40, 32'hCAFEF00D);
    n = 0;
    do begin cyc(); n++; end while (!gnt0 && n < 8);
    n_cmp++; if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL rst_mid_gnt: gnt0 %b want 1", gnt0); end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, OP_W, 32'h40, 32'hCAFEF00D);
    #1;
    n_cmp++; if ({mem_MemEn, mem_WrEn} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_gate: MemEn/WrEn %b want 00", {mem_MemEn, mem_WrEn}); end
    cyc();
    rst = 1'b0;
    #1;
    n_cmp++; if ({mem[12'h43], mem[12'h42], mem[12'h41], mem[12'h40]} !== 32'h0) begin n_bad++; $display("FAIL rst_mid_nowrite: mem[40] %h want 00000000", {mem[12'h43], mem[12'h42], mem[12'h41], mem[12'h40]}); end
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_cmp++;
      if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_quiet cycle %0d: gnt/rvalid %b want 0000", c, {gnt0, gnt1, rvalid0, rvalid1}); end
    end

    drive(1'b0, 1'b1, 1'b0, OP_W,  32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, OP_BU, 32'h21, 32'h0);
    n = 0;
    do begin cyc(); n++; end while (!(gnt0 || gnt1) && n < 8);
    n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_bad++; $display("FAIL rst_mid_tie: gnt0/gnt1 %b want 10", {gnt0, gnt1}); end
    req0 = 1'b0;
    req1 = 1'b0;
    cyc();
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    op0 = 3'b000; op1 = 3'b000; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    test_reset();
    test_store_load();
    test_extension();
    test_round_robin();
    test_errors();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-addressed data memory between two requesters: port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Round-robin arbitration; one access in flight at a time.
- Rejects illegal, misaligned or out-of-range accesses before they reach memory.
- Sits between the requesters and the data memory's WrEn/MemEn/MemOp/Addr/DataIn/DataOut interface; memory read is combinational, write commits on posedge clk.

Parameters:
- DEPTH, 4096: memory size in bytes; legal byte addresses are 0..DEPTH-1.
- ADDR_W, 32: address width of requester and memory ports.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request, port 0 / port 1.
- we0 / we1  in  1  1 = store, 0 = load.
- op0 / op1  in  3  MemOp: 000 word, 001 byte signed, 010 half signed, 101 byte unsigned, 110 half unsigned.
- addr0 / addr1  in  ADDR_W  byte address.
- wdata0 / wdata1  in  32  store data; low bits used for byte/half.
- gnt0 / gnt1  out  1  one-cycle pulse: request latched, fields may change next cycle.
- rvalid0 / rvalid1  out  1  one-cycle response pulse.
- rdata  out  32  load result, valid with rvalidN; 0 for stores and errors.
- err  out  1  valid with rvalidN; 1 = access rejected.
- mem_WrEn  out  1  memory write enable.
- mem_MemEn  out  1  memory enable.
- mem_MemOp  out  3  MemOp to memory.
- mem_Addr  out  ADDR_W  address to memory.
- mem_DataIn  out  32  store data to memory.
- mem_DataOut  in  32  combinational read data from memory.

Behaviour:
- Reset: state IDLE, rr pointer = port 0 preferred. gnt*, rvalid*, err, rdata, mem_* all 0.
- FSM IDLE -> ACCESS -> RESP -> IDLE. Throughput is one access per 3 cycles.
- IDLE:
  - If exactly one req is high, select that port.
  - If both are high, select the rr-preferred port.
  - Latch we/op/addr/wdata and the selected id; set err_q from the checker; go to ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - gntN = 1 for the latched port.
  - Memory ports are driven from latched fields.
  - mem_MemEn = !err_q & !rst; mem_WrEn = we_q & !err_q & !rst.
  - Loads: capture mem_DataOut into rdata at the end of the cycle.
  - Stores and errors: rdata <= 0.
  - Next state is RESP.
- RESP:
  - rvalidN = 1 and err = err_q for the latched port.
  - rr preference flips to the other port.
  - Next state is IDLE.
- Outside ACCESS, all mem_* outputs = 0. gnt and rvalid are never asserted to both ports at once.
- Latency: req high at T (state IDLE) -> gnt at T+1, memory access at T+1, rvalid at T+2. The earliest next latch is T+3.
- Requesters hold req and fields stable until gnt. A req still high after gnt is treated as a new request.
- Legality check (err = 1, no memory enable):
  - Word with addr[1:0] != 0.
  - Half (010/110) with addr[0] != 0.
  - Store with op not in {000, 001, 010}.
  - Load with op in {011, 100, 111}.
  - addr + size - 1 >= DEPTH (size 4/2/1).
- Fairness: a port that loses a tie is preferred on the next tie, so neither port starves.
- Reset mid-operation: the FSM returns to IDLE with no write committed in the reset cycle (enables gated by rst). No rvalid is issued for the aborted access. The rr pointer returns to port 0.

Decomposition:
- Shared package dmem_pkg:
  - MemOp constants OP_W = 3'b000, OP_BS = 3'b001, OP_HS = 3'b010, OP_BU = 3'b101, OP_HU = 3'b110.
  - FSM state encoding: IDLE, ACCESS, RESP.
  - Function for access size in bytes per op.
- Sub-module dmem_req_check: combinational legality check taking we, op, addr and DEPTH, producing err. It is reused later by the pipelined CPU LSU.

Test Plan:
- Reset then idle: rst high 2 cycles -> all outputs 0 and mem_MemEn = 0 for 10 idle cycles.
- Port-0 word store then load: store addr 0x10, wdata 0xDEADBEEF, op 000 -> gnt0 at T+1 with mem_WrEn = 1, Addr 0x10, and rvalid0 at T+2 with err = 0. A following load of 0x10 -> rdata = 0xDEADBEEF.
- Sign/zero extension: store byte 0x80 at addr 0x21. Load op 001 -> 0xFFFFFF80; load op 101 -> 0x00000080.
- Simultaneous requests:
  - req0 and req1 high continuously after reset -> grants alternate 0, 1, 0, 1.
  - Each port gets exactly one gnt per won access; gnt0 and gnt1 are never high together.
- Errors:
  - Word load at 0x02 -> err = 1, rdata = 0, mem_MemEn = 0.
  - Store op 101 -> err = 1.
  - Word load at 0xFFE (DEPTH 4096) -> err = 1.
  - In all three cases memory contents are unchanged.
- Reset during ACCESS of a store to 0x40 -> no write to 0x40, no rvalid, FSM in IDLE, next tie granted to port 0.
